// File: rtl/cond_eval.sv
// cond_eval: architectural flag register and condition evaluator.
// Stalls issue while flag-setting instructions are in flight. A small
// in-order FIFO records whether each in-flight flag-setter executed, so
// that flags returned for squashed instructions are discarded.
module cond_eval #(
  parameter int PENDING_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [3:0] issue_cond,
  input  logic       issue_setflags,
  output logic       issue_ready,
  output logic       ex_valid,
  output logic       ex_pass,
  input  logic       flag_valid,
  input  logic [4:0] flag_in,
  input  logic [4:0] flag_we,
  output logic [4:0] flags_q,
  output logic [2:0] pending,
  output logic       err
);

  localparam logic [2:0] PEND_FULL = 3'(PENDING_MAX);
  localparam logic [2:0] PTR_LAST  = 3'(PENDING_MAX - 1);

  // Flag bit positions inside {EQ,N,Z,C,V}
  localparam int B_EQ = 4;
  localparam int B_N  = 3;
  localparam int B_Z  = 2;
  localparam int B_C  = 1;
  localparam int B_V  = 0;

  // Evaluate a 4-bit condition code against a flag vector
  function automatic logic eval_cond(input logic [3:0] cond, input logic [4:0] f);
    logic eq, n, z, c, v, r;
    eq = f[B_EQ];
    n  = f[B_N];
    z  = f[B_Z];
    c  = f[B_C];
    v  = f[B_V];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = eq;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Circular pointer advance, wrapping at the last FIFO slot
  function automatic logic [2:0] ptr_next(input logic [2:0] p);
    return (p == PTR_LAST) ? 3'd0 : p + 3'd1;
  endfunction

  logic [PENDING_MAX-1:0] fifo_q;
  logic [2:0]             wptr_q;
  logic [2:0]             rptr_q;
  logic [2:0]             pend_q;
  logic [4:0]             flags_r;
  logic                   err_r;
  logic                   vld_p1;
  logic                   pass_p1;

  logic cond_res;
  logic stall_dep;
  logic stall_full;
  logic accept;
  logic push;
  logic pop;
  logic head;

  // Issue-side decision: conditions only read architectural flags, so any
  // in-flight flag-setter blocks non-AL instructions; the full check uses
  // the count before any pop in this cycle.
  always_comb begin
    cond_res    = eval_cond(issue_cond, flags_r);
    stall_dep   = (issue_cond != 4'hF) && (pend_q != 3'd0);
    stall_full  = issue_setflags && (pend_q == PEND_FULL);
    issue_ready = ~issue_valid | ~(stall_dep | stall_full);
    accept      = issue_valid & issue_ready;
    push        = accept & issue_setflags;
    pop         = flag_valid && (pend_q != 3'd0);
  end

  // Select the pass bit at the FIFO read pointer
  always_comb begin
    head = 1'b0;
    for (int i = 0; i < PENDING_MAX; i++) begin
      if (rptr_q == 3'(i)) head = fifo_q[i];
    end
  end

  // Pass-bit storage; emptiness is tracked by the pointers and count
  always_ff @(posedge clk) begin
    for (int i = 0; i < PENDING_MAX; i++) begin
      if (push && (wptr_q == 3'(i))) fifo_q[i] <= cond_res;
    end
  end

  // Stage p0 -> p1: execute-stage valid and condition result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pass_p1 <= 1'b0;
    end else begin
      vld_p1  <= accept;
      pass_p1 <= accept & cond_res;
    end
  end

  // FIFO pointers and in-flight count; push and pop together leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 3'd0;
      rptr_q <= 3'd0;
      pend_q <= 3'd0;
    end else begin
      if (push) wptr_q <= ptr_next(wptr_q);
      if (pop)  rptr_q <= ptr_next(rptr_q);
      if (push && !pop)      pend_q <= pend_q + 3'd1;
      else if (pop && !push) pend_q <= pend_q - 3'd1;
    end
  end

  // Flag writeback from executed flag-setters; stray returns raise sticky err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 5'd0;
      err_r   <= 1'b0;
    end else begin
      if (pop && head) flags_r <= (flag_we & flag_in) | (~flag_we & flags_r);
      if (flag_valid && (pend_q == 3'd0)) err_r <= 1'b1;
    end
  end

  assign ex_valid = vld_p1;
  assign ex_pass  = pass_p1;
  assign flags_q  = flags_r;
  assign pending  = pend_q;
  assign err      = err_r;

endmodule

// File: tb/tb_cond_eval.sv
// tb_cond_eval: table-driven bench for cond_eval with an ex_pass scoreboard.
module tb_cond_eval;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [3:0] issue_cond;
  logic       issue_setflags;
  logic       issue_ready;
  logic       ex_valid;
  logic       ex_pass;
  logic       flag_valid;
  logic [4:0] flag_in;
  logic [4:0] flag_we;
  logic [4:0] flags_q;
  logic [2:0] pending;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       iv;
    logic [3:0] cond;
    logic       sf;
    logic       fv;
    logic [4:0] fin;
    logic [4:0] fwe;
    logic       rdy;
    logic       pass;
    logic [4:0] flags;
    logic [2:0] pend;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  logic sb[$];

  cond_eval #(.PENDING_MAX(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_cond    (issue_cond),
    .issue_setflags(issue_setflags),
    .issue_ready   (issue_ready),
    .ex_valid      (ex_valid),
    .ex_pass       (ex_pass),
    .flag_valid    (flag_valid),
    .flag_in       (flag_in),
    .flag_we       (flag_we),
    .flags_q       (flags_q),
    .pending       (pending),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input int iv, input int cond, input int sf,
                              input int fv, input int fin, input int fwe,
                              input int rdy, input int pass, input int flags,
                              input int pend, input int e);
    vec_t v;
    v.iv    = 1'(iv);
    v.cond  = 4'(cond);
    v.sf    = 1'(sf);
    v.fv    = 1'(fv);
    v.fin   = 5'(fin);
    v.fwe   = 5'(fwe);
    v.rdy   = 1'(rdy);
    v.pass  = 1'(pass);
    v.flags = 5'(flags);
    v.pend  = 3'(pend);
    v.err   = 1'(e);
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check ready before the edge and state after it
  task automatic apply(input vec_t v, input int idx);
    logic exp_pass;
    @(negedge clk);
    issue_valid    = v.iv;
    issue_cond     = v.cond;
    issue_setflags = v.sf;
    flag_valid     = v.fv;
    flag_in        = v.fin;
    flag_we        = v.fwe;
    #1;
    chk($sformatf("ready[%0d]", idx), 8'(issue_ready), 8'(v.rdy));
    if (v.iv && v.rdy) sb.push_back(v.pass);
    @(posedge clk);
    #1;
    chk($sformatf("flags[%0d]", idx), 8'(flags_q), 8'(v.flags));
    chk($sformatf("pending[%0d]", idx), 8'(pending), 8'(v.pend));
    chk($sformatf("err[%0d]", idx), 8'(err), 8'(v.err));
    chk($sformatf("ex_valid[%0d]", idx), 8'(ex_valid), 8'(v.iv && v.rdy));
    if (ex_valid) begin
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty[%0d]", idx), 8'd1, 8'd0);
      end else begin
        exp_pass = sb.pop_front();
        chk($sformatf("ex_pass[%0d]", idx), 8'(ex_pass), 8'(exp_pass));
      end
    end else begin
      chk($sformatf("ex_pass_idle[%0d]", idx), 8'(ex_pass), 8'd0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    issue_valid    = 1'b0;
    issue_cond     = 4'h0;
    issue_setflags = 1'b0;
    flag_valid     = 1'b0;
    flag_in        = 5'd0;
    flag_we        = 5'd0;

    // Columns: iv cond sf | fv fin fwe | rdy pass flags pend err
    // Dependency stall: AL setflags, EQ waits, flags return, EQ accepted
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00000, 1, 0));
    tbl.push_back(mk(1, 'h0, 0, 0, 0, 0, 0, 0, 'b00000, 1, 0));
    tbl.push_back(mk(1, 'h0, 0, 1, 'b00100, 'h1F, 0, 0, 'b00100, 0, 0));
    tbl.push_back(mk(1, 'h0, 0, 0, 0, 0, 1, 1, 'b00100, 0, 0));
    // Clear flags, then a squashed flag-setter whose return is dropped
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00100, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b00000, 'h1F, 1, 0, 'b00000, 0, 0));
    tbl.push_back(mk(1, 'h0, 1, 0, 0, 0, 1, 0, 'b00000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'h1F, 'h1F, 1, 0, 'b00000, 0, 0));
    // Load 00110, then partial write with we=00011 -> 00101
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b00110, 'h1F, 1, 0, 'b00110, 0, 0));
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00110, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b11101, 'b00011, 1, 0, 'b00101, 0, 0));
    // All condition codes against EQ=0 N=0 Z=1 C=0 V=1
    tbl.push_back(mk(1, 'h0, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h1, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h2, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h3, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h4, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h5, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h6, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h7, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h8, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'h9, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hA, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hB, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hC, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hD, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hE, 0, 0, 0, 0, 1, 0, 'b00101, 0, 0));
    tbl.push_back(mk(1, 'hF, 0, 0, 0, 0, 1, 1, 'b00101, 0, 0));
    // Full FIFO across pointer wrap: NE (fails) then AL, AL; fourth stalls
    tbl.push_back(mk(1, 'h1, 1, 0, 0, 0, 1, 0, 'b00101, 1, 0));
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00101, 2, 0));
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00101, 3, 0));
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 0, 0, 'b00101, 3, 0));
    tbl.push_back(mk(1, 'hF, 1, 1, 'h1F, 'h1F, 0, 0, 'b00101, 2, 0));
    tbl.push_back(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b00101, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b11000, 'h1F, 1, 0, 'b11000, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b00011, 'b00011, 1, 0, 'b11011, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 'b10010, 'h1F, 1, 0, 'b10010, 0, 0));
    // Stray flag return: sticky err, flags unchanged
    tbl.push_back(mk(0, 0, 0, 1, 'h1F, 'h1F, 1, 0, 'b10010, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 'b10010, 0, 1));

    // Reset state
    #12;
    chk("rst_ex_valid", 8'(ex_valid), 8'd0);
    chk("rst_ex_pass", 8'(ex_pass), 8'd0);
    chk("rst_flags", 8'(flags_q), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_ready", 8'(issue_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Mid-stream reset with pending=2 and flags=10101
    apply(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b10010, 1, 1), 100);
    apply(mk(0, 0, 0, 1, 'b10101, 'h1F, 1, 0, 'b10101, 0, 1), 101);
    apply(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b10101, 1, 1), 102);
    apply(mk(1, 'hF, 1, 0, 0, 0, 1, 1, 'b10101, 2, 1), 103);
    @(negedge clk);
    issue_valid    = 1'b1;
    issue_cond     = 4'h0;
    issue_setflags = 1'b0;
    flag_valid     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 8'(ex_valid), 8'd0);
    chk("arst_ex_pass", 8'(ex_pass), 8'd0);
    chk("arst_flags", 8'(flags_q), 8'd0);
    chk("arst_pending", 8'(pending), 8'd0);
    chk("arst_err", 8'(err), 8'd0);
    chk("arst_ready", 8'(issue_ready), 8'd1);
    @(posedge clk);
    #1;
    chk("arst_hold_ex_valid", 8'(ex_valid), 8'd0);
    sb.delete();
    @(negedge clk);
    issue_valid = 1'b0;
    rst_n       = 1'b1;
    // FIFO empty after release: a flag return is a stray, EQ issues at once
    apply(mk(0, 0, 0, 1, 'h1F, 'h1F, 1, 0, 'b00000, 0, 1), 104);
    apply(mk(1, 'h0, 0, 0, 0, 0, 1, 0, 'b00000, 0, 1), 105);

    @(negedge clk);
    issue_valid = 1'b0;
    flag_valid  = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_eval.md
# cond_eval

Condition-evaluation and flag-register block for the 16-bit datapath. It holds the architectural flags produced by the ALU flag generator ({EQ,N,Z,C,V}), evaluates each issued instruction's 4-bit condition field against them, and stalls issue while flag-setting instructions are still in flight. A small in-order FIFO records whether each in-flight flag-setter actually executed, so that flags returned for squashed instructions are discarded.

## Interface
- PENDING_MAX, 3: maximum number of in-flight flag-setting instructions (FIFO depth, range 1-7).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_cond  in  4  condition code of the presented instruction.
- issue_setflags  in  1  presented instruction will write flags.
- issue_ready  out  1  combinational; instruction accepted when issue_valid & issue_ready.
- ex_valid  out  1  registered; an instruction was accepted in the previous cycle.
- ex_pass  out  1  registered; condition result of that instruction.
- flag_valid  in  1  ALU returns flags for the oldest in-flight flag-setter.
- flag_in  in  5  returned flags, bit order {EQ,N,Z,C,V} (bit4..bit0).
- flag_we  in  5  per-bit write enable for flag_in.
- flags_q  out  5  architectural flags, same bit order.
- pending  out  3  in-flight flag-setter count.
- err  out  1  sticky protocol error.

## Operation
- Condition decode (N,Z,C,V,EQ taken from flags_q):
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C. 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z. A GE: N==V. B LT: N!=V. C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E CMPEQ: EQ. F AL: 1.
- Stall rules. issue_ready=0 when either:
  - issue_cond!=F and pending!=0 (no bypass: flags must be architectural before they are evaluated); or
  - issue_setflags=1 and pending==PENDING_MAX.
  - Otherwise issue_ready=1. It is also 1 when issue_valid=0.
- On accept:
  - ex_valid<=1 and ex_pass<=cond result; otherwise ex_valid<=0 and ex_pass<=0.
  - If issue_setflags=1, push the cond result onto the pass FIFO and increment pending.
- On flag_valid with pending!=0:
  - Pop the FIFO head.
  - If the head is 1: flags_q[i]<=flag_we[i] ? flag_in[i] : flags_q[i]. If the head is 0: flags_q is unchanged.
  - Decrement pending.
- Push and pop in the same cycle: pending is unchanged and FIFO order is preserved. The full-stall decision uses the pre-pop pending, so a setflags issue arriving while a pop is in progress on a full FIFO still stalls for that cycle.
- flag_valid with pending==0: err<=1 (sticky until reset); flags_q, pending and the FIFO are unchanged.
- Counter arithmetic: pending never wraps. Pushes stall at PENDING_MAX; pops are ignored at 0.

## Timing
- Reset (asynchronous, also mid-operation): flags_q=0, pending=0, FIFO empty, ex_valid=0, ex_pass=0, err=0.
- Latencies:
  - issue_ready: combinational from issue_* and registered state.
  - ex_valid / ex_pass: 1 cycle after accept.
  - flags_q: updates on the clk edge that samples flag_valid.
  - A stalled conditional instruction is accepted in the cycle after the edge on which pending reaches 0.
- FIFO storage: PENDING_MAX bits, circular read/write pointers with wrap-around at PENDING_MAX-1.

## Test plan
- Reset: assert rst_n=0 mid-stream with pending=2 and flags_q=5'b10101 -> all outputs 0 immediately, issue_ready=1, FIFO empty after release.
- Flag dependency stall:
  - Issue AL setflags -> next cycle ex_valid=1, ex_pass=1, pending=1.
  - Hold issue_cond=0 (EQ) -> issue_ready=0.
  - Drive flag_valid with flag_in=5'b00100, flag_we=5'b11111 -> flags_q=5'b00100; next cycle issue_ready=1, then ex_pass=1.
- Squashed flag-setter: flags_q=0, issue cond 0 with setflags -> ex_pass=0, pending=1; flag_valid with flag_in=5'b11111 -> flags_q stays 5'b00000, pending=0.
- Partial write: flags_q=5'b00110, flag_in=5'b11101, flag_we=5'b00011 -> flags_q=5'b00101.
- Full FIFO (PENDING_MAX=3):
  - Three AL setflags accepted back-to-back -> pending=3.
  - Fourth stalls, including in the cycle flag_valid pops.
  - Fourth is accepted the next cycle -> pending=3.
  - Verify pass bits pop in order across pointer wrap-around.
- Protocol error: flag_valid with pending=0 -> err=1 next edge and stays 1, flags_q unchanged; rst_n low clears err.
